mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same forwarded SrcA/SrcB operands and produces a result that the EX-stage result mux selects in place of ALUResult. The operation runs for a fixed number of cycles. The hazard unit stalls IF/ID/EX while busy is high and flushes the unit on a pipeline kill.

Parameters:
DATA_WIDTH, 32, operand/result width; also the iteration count.
OP_LENGTH, 3, op encoding width (RV32M funct3).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
op  in  OP_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  in  DATA_WIDTH  rs1 operand (multiplicand/dividend)
SrcB  in  DATA_WIDTH  rs2 operand (multiplier/divisor)
flush  in  1  abort the in-flight operation
busy  out  1  operation in flight; used as the stall request
done  out  1  one-cycle pulse; Result valid
Result  out  DATA_WIDTH  final result; held until the next completion

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state goes to IDLE; busy=0, done=0, Result=0; counter and internal registers cleared.
  - reset wins over start and flush.
  - reset mid-operation discards the operation; no done is produced.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN: start=1 at an edge while busy=0.
  - RUN -> FIX: after the DATA_WIDTH-th step.
  - FIX -> IDLE: after one cycle.
- Accept at edge k:
  - Latch op and the operand sign flags.
  - Latch operand magnitudes: |A| if op is MUL/MULH/MULHSU/DIV/REM; |B| if op is MUL/MULH/DIV/REM; otherwise the raw bits.
  - counter=0; busy=1 from edge k.
- RUN performs one step per cycle, DATA_WIDTH steps (edges k+1..k+DATA_WIDTH):
  - Multiply: radix-2 shift-add into a 2*DATA_WIDTH product register.
  - Divide: restoring shift-subtract, producing quotient and remainder registers.
- FIX, edge k+DATA_WIDTH+1:
  - Apply the sign correction and select the result.
  - Register Result; done=1 for exactly that cycle; busy=0 from that edge.
  - Total latency: done high DATA_WIDTH+1 cycles after the accepting edge (33 for the default).
- Result selection:
  - MUL: low word of the signed product.
  - MULH/MULHSU/MULHU: high word of the signed×signed, signed×unsigned and unsigned×unsigned products respectively.
  - DIV/DIVU: quotient, truncated toward zero.
  - REM/REMU: remainder; the sign of a signed remainder follows the dividend.
  - Product negation is 2*DATA_WIDTH wide, two's complement.
- Special cases: fixed latency still applies; overrides are applied in FIX.
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- start while busy=1: ignored; operands are not re-latched.
- start in the cycle done=1: accepted, so back-to-back operations are possible.
- op/SrcA/SrcB are don't-care except at the accepting edge.
- flush=1 at an edge while RUN or FIX:
  - next state IDLE; busy=0; no done pulse; Result keeps its previous value.
  - flush in IDLE has no effect.
  - flush together with start in IDLE: flush wins; the request is dropped.
- Counter width is $clog2(DATA_WIDTH)+1; it saturates into FIX and never wraps into a second pass.

Decomposition:
- Package mdu_pkg holds:
  - the op enum (mdu_op_e, funct3 values above);
  - the state enum (mdu_state_e: IDLE, RUN, FIX);
  - is_signed_a/is_signed_b/is_div helper functions;
  - DIV_ZERO_Q constant (all ones).
- One natural sub-module: mdu_signfix, the combinational sign-correction and special-case override used in FIX. It is kept separate so it can be unit-tested exhaustively at small DATA_WIDTH.
- Datapath registers and the FSM stay in mdu_iterative.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD (−3), start pulsed at edge 0 -> busy high from edge 0; done high exactly in the cycle after edge 33; Result=0xFFFFFFEB.
- High-word products -> MULH 0x80000000×0x80000000 gives 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
- Signed division -> DIV −7/2 gives 0xFFFFFFFD; REM −7%2 gives 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 gives 0x7FFFFFFC; REMU gives 1.
- Special cases -> DIVU 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0. All complete with the 33-cycle latency.
- Handshake:
  - second start at edge 5 with different operands -> ignored; first result unchanged.
  - start held high in the done cycle -> new operation accepted; its done arrives 33 edges later.
- Aborts:
  - flush at edge 10 -> busy=0 after edge 10; no done for 40 cycles; Result unchanged.
  - reset at edge 12 of an operation -> busy=0, done=0, Result=0.
  - then MUL 3×4 -> Result=12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types, constants and op-decode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Quotient for a zero divisor; sliced down to the datapath width by users.
    localparam logic [63:0] DIV_ZERO_Q = '1;

    // rs1 is treated as two's complement
    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as two's complement
    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Sign correction and special-case override applied to the unsigned magnitude result.
// For multiplies i_acc is the 2W product; for divides i_acc is {remainder, quotient}.
module mdu_signfix
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  mdu_op_e                   i_op,
    input  logic [2*DATA_WIDTH-1:0]   i_acc,
    input  logic                      i_neg_a,
    input  logic                      i_neg_b,
    input  logic                      i_div_zero,
    input  logic                      i_ovf,
    output logic [DATA_WIDTH-1:0]     o_result
);

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_quo;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_min;

    // Sign flags are already zero for operands treated as unsigned.
    assign w_prod = (i_neg_a ^ i_neg_b) ? -i_acc : i_acc;
    assign w_quo  = (i_neg_a ^ i_neg_b) ? -i_acc[DATA_WIDTH-1:0] : i_acc[DATA_WIDTH-1:0];
    // Remainder takes the dividend's sign; with a zero divisor this reproduces the dividend.
    assign w_rem  = i_neg_a ? -i_acc[2*DATA_WIDTH-1:DATA_WIDTH] : i_acc[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_min  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Select the architectural result for the latched op
    always_comb begin
        o_result = '0;
        unique case (i_op)
            OP_MUL:                        o_result = w_prod[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  o_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU: begin
                if (i_div_zero)  o_result = DIV_ZERO_Q[DATA_WIDTH-1:0];
                else if (i_ovf)  o_result = w_min;
                else             o_result = w_quo;
            end
            OP_REM, OP_REMU: begin
                if (i_div_zero)  o_result = w_rem;
                else if (i_ovf)  o_result = '0;
                else             o_result = w_rem;
            end
            default:             o_result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, fixed DATA_WIDTH+1 latency.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_LENGTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OP_LENGTH-1:0]  op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    mdu_state_e              r_state, w_state_next;
    mdu_op_e                 r_op;
    logic [CW-1:0]           r_cnt;
    logic                    r_neg_a, r_neg_b, r_ovf;
    // Multiply: |A| added into the product; divide: |B| divisor.
    logic [DATA_WIDTH-1:0]   r_opnd;
    // Multiply: {product hi, multiplier/product lo}; divide: {remainder, dividend/quotient}.
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_done;

    mdu_op_e                 w_op_in;
    logic                    w_sa, w_sb, w_accept, w_last, w_fix_go;
    logic [DATA_WIDTH-1:0]   w_mag_a, w_mag_b, w_fix_result;
    logic [DATA_WIDTH:0]     w_sum, w_diff;
    logic [2*DATA_WIDTH-1:0] w_mul_next, w_div_next;

    assign w_op_in  = mdu_op_e'(op);
    assign w_sa     = is_signed_a(w_op_in) & SrcA[DATA_WIDTH-1];
    assign w_sb     = is_signed_b(w_op_in) & SrcB[DATA_WIDTH-1];
    assign w_mag_a  = w_sa ? -SrcA : SrcA;
    assign w_mag_b  = w_sb ? -SrcB : SrcB;
    assign w_accept = (r_state == IDLE) & start & ~flush;
    assign w_last   = (r_cnt == CW'(DATA_WIDTH - 1));
    assign w_fix_go = (r_state == FIX) & ~flush;

    // Shift-add: conditionally add into the high half, then shift the whole product right.
    assign w_sum      = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                        + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[DATA_WIDTH-1:1]};

    // Restoring divide: trial-subtract the divisor from the shifted partial remainder.
    assign w_diff     = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1] - {1'b0, r_opnd};
    assign w_div_next = w_diff[DATA_WIDTH]
                        ? {r_acc[2*DATA_WIDTH-2:0], 1'b0}
                        : {w_diff[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};

    mdu_signfix #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_signfix (
        .i_op       (r_op),
        .i_acc      (r_acc),
        .i_neg_a    (r_neg_a),
        .i_neg_b    (r_neg_b),
        .i_div_zero (is_div(r_op) & (r_opnd == '0)),
        .i_ovf      (r_ovf),
        .o_result   (w_fix_result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; flush returns to IDLE from RUN or FIX
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN: begin
                if (flush)       w_state_next = IDLE;
                else if (w_last) w_state_next = FIX;
            end
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_ovf    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fix_go;
            if (w_fix_go) r_result <= w_fix_result;
            if (w_accept) begin
                r_op    <= w_op_in;
                r_cnt   <= '0;
                r_neg_a <= w_sa;
                r_neg_b <= w_sb;
                r_ovf   <= is_div(w_op_in) & is_signed_b(w_op_in)
                           & (SrcA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (SrcB == '1);
                r_opnd  <= is_div(w_op_in) ? w_mag_b : w_mag_a;
                r_acc   <= {{DATA_WIDTH{1'b0}}, (is_div(w_op_in) ? w_mag_a : w_mag_b)};
            end else if ((r_state == RUN) && !flush) begin
                r_acc <= is_div(r_op) ? w_div_next : w_mul_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign Result = r_result;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: results, latency, handshake, flush and reset abort.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] SrcA, SrcB;
    logic        busy, done;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;

    mdu_iterative #(
        .DATA_WIDTH (32),
        .OP_LENGTH  (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request one step after an edge; returns after the accepting edge (+1).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after the accepting edge until done; 0 means it never came.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        int n;
        issue(o, a, b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, "_lat"}, n, 32'd33);
        check({tag, "_res"}, Result, exp);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; SrcA = '0; SrcB = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res",  Result, 32'd0);

        run("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        check("mul_busy_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("res_held", Result, 32'hFFFFFFEB);

        run("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run("divu",    3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC);
        run("remu",    3'b111, 32'hFFFFFFF9, 32'd2,        32'd1);
        run("divu0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF);
        run("remu0",   3'b111, 32'd5,        32'd0,        32'd5);
        run("div0",    3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
        run("rem0",    3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
        run("divovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run("removf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        run("div_pos", 3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2);

        // Second start at edge 5 must be ignored
        issue(3'b000, 32'd7, 32'hFFFFFFFD);
        repeat (4) @(posedge clk);
        #1;
        op = 3'b100; SrcA = 32'd100; SrcB = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 6; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("ign_lat", lat, 32'd33);
        check("ign_res", Result, 32'hFFFFFFEB);

        // Start held in the done cycle: back-to-back acceptance
        op = 3'b000; SrcA = 32'd5; SrcB = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("b2b_lat", lat, 32'd33);
        check("b2b_res", Result, 32'd30);

        // Flush at edge 10 drops the operation
        issue(3'b000, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("flush_nodone", seen, 32'd0);
        check("flush_res", Result, 32'd30);

        // Flush together with start in IDLE drops the request
        op = 3'b000; SrcA = 32'd2; SrcB = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);

        // Reset at edge 12 aborts the operation and clears the result
        issue(3'b000, 32'd11, 32'd11);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_res",  Result, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("rst_nodone", seen, 32'd0);

        run("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
